// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundles the fetch, data and shared-RAM signals of the memory port arbiter.
// Latency : none; this is wiring only.
// Backpress: requesters hold req/addr/data until their ack; acks are the only backpressure.
// Ports   : slave  = arbiter side (takes requests and ram_rdata, drives acks/rdata/ram_*),
//           master = requester/memory side (mirror image of slave).
interface mem_port_arbiter_if;
  // fetch side
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        if_stall;
  // data side
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_ack;
  logic        dm_rvalid;
  logic [15:0] dm_rdata;
  // shared single-port RAM
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    output if_ack, if_rvalid, if_rdata, if_stall,
    output dm_ack, dm_rvalid, dm_rdata,
    output ram_addr, ram_we, ram_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    input  if_ack, if_rvalid, if_rdata, if_stall,
    input  dm_ack, dm_rvalid, dm_rdata,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one synchronous-read RAM port between instruction fetch and data access.
// Latency : grant one edge after req; read data (rvalid) one cycle after the grant cycle.
// Backpress: loser of arbitration is held off by a low ack; data wins ties, but fetch is
//            forced through after STARVE_LIMIT consecutive data grants while it waits.
// Ports   : clk, reset (async, active-high), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3  // legal 1..15
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_DM = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // state names the owner of the RAM port in the current cycle
  state_t     state;
  logic [3:0] starve_cnt;
  logic       if_rvalid_q;
  logic       dm_rvalid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      // the access owning the port this cycle returns data next cycle (reads only)
      if_rvalid_q <= (state == ACC_IF);
      dm_rvalid_q <= (state == ACC_DM) && !bus.dm_we;

      // A req still high through its own ack cycle is treated as a fresh request,
      // so back-to-back grants to the same side need no idle cycle.
      if (bus.if_req && bus.dm_req) begin
        if (starve_cnt == LIMIT) begin
          state      <= ACC_IF;
          starve_cnt <= 4'd0;
        end else begin
          // cannot pass LIMIT: reaching it forces the next tie to fetch
          state      <= ACC_DM;
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else if (bus.if_req) begin
        state      <= ACC_IF;
        starve_cnt <= 4'd0;
      end else if (bus.dm_req) begin
        // fetch not waiting, so nothing is being starved
        state      <= ACC_DM;
        starve_cnt <= 4'd0;
      end else begin
        state      <= IDLE;
        starve_cnt <= 4'd0;
      end
    end
  end

  assign bus.if_ack    = (state == ACC_IF);
  assign bus.dm_ack    = (state == ACC_DM);
  assign bus.if_stall  = bus.if_req && (state != ACC_IF);

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rvalid_q ? bus.ram_rdata : 16'd0;
  assign bus.dm_rdata  = dm_rvalid_q ? bus.ram_rdata : 16'd0;

  // RAM port steering follows the registered owner, so reset (state -> IDLE)
  // drops ram_we immediately without waiting for a clock.
  always_comb begin
    bus.ram_addr  = 16'd0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = 16'd0;
    case (state)
      ACC_IF: begin
        bus.ram_addr = bus.if_addr;
      end
      ACC_DM: begin
        bus.ram_addr  = bus.dm_addr;
        bus.ram_we    = bus.dm_we;
        bus.ram_wdata = bus.dm_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter with a transaction-level model.
// Latency : model predicts owner per cycle and read data one cycle after each read grant.
// Backpress: requesters hold their request until acked, then drop or stream the next one.
module tb_mem_port_arbiter;

  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- memory behind the port (sync read, one cycle) ----------------
  logic [15:0] ram [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_dat;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_dat;
    else if (bus.ram_we) ram[bus.ram_addr[7:0]] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr[7:0]];
  end

  // ---------------- reference model state ----------------
  // owner codes: 0 = nobody, 1 = fetch, 2 = data
  int          m_grant;
  int          m_dm_run;      // data grants in a row while fetch has been waiting
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_we;
  logic [15:0] shadow [0:255];
  logic        exp_if_rv, exp_dm_rv;
  logic [15:0] exp_if_dat, exp_dm_dat;

  // requester behaviour knobs
  int p_if_new, p_dm_new, p_keep;
  bit stream_mode, if_adv, dm_adv;

  int n_tests, n_fail;

  task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] rnd_addr();
    return 16'($urandom_range(31, 0));
  endfunction

  // One clock cycle: model arbitration at the edge, requester reaction, then checks.
  task automatic step();
    logic s_if, s_dm;
    int   g;
    s_if = bus.if_req;
    s_dm = bus.dm_req;
    @(posedge clk);
    // retire the access that owned the port in the cycle just ended
    exp_if_rv = (m_grant == 1);
    exp_dm_rv = (m_grant == 2) && !m_we;
    if (m_grant == 1) exp_if_dat = shadow[m_addr[7:0]];
    if (m_grant == 2) begin
      if (m_we) shadow[m_addr[7:0]] = m_wdata;
      else      exp_dm_dat = shadow[m_addr[7:0]];
    end
    // pick the new owner from the requests seen at this edge
    if (s_if && s_dm) g = (m_dm_run >= LIMIT) ? 1 : 2;
    else if (s_if)    g = 1;
    else if (s_dm)    g = 2;
    else              g = 0;
    m_dm_run = (g == 2 && s_if) ? m_dm_run + 1 : 0;
    m_grant  = g;
    #1;
    // streamed requests present their next address at the edge after the ack
    if (if_adv) begin
      if_adv      = 1'b0;
      bus.if_addr = stream_mode ? bus.if_addr + 16'd1 : rnd_addr();
    end
    if (dm_adv) begin
      dm_adv       = 1'b0;
      bus.dm_addr  = rnd_addr();
      bus.dm_we    = 1'($urandom_range(1, 0));
      bus.dm_wdata = 16'($urandom);
    end
    if (g == 1) begin
      if (int'($urandom_range(99, 0)) < p_keep) if_adv = 1'b1;
      else bus.if_req = 1'b0;
    end else if (!bus.if_req && int'($urandom_range(99, 0)) < p_if_new) begin
      bus.if_req  = 1'b1;
      bus.if_addr = rnd_addr();
    end
    if (g == 2) begin
      if (int'($urandom_range(99, 0)) < p_keep) dm_adv = 1'b1;
      else bus.dm_req = 1'b0;
    end else if (!bus.dm_req && int'($urandom_range(99, 0)) < p_dm_new) begin
      bus.dm_req   = 1'b1;
      bus.dm_addr  = rnd_addr();
      bus.dm_we    = 1'($urandom_range(1, 0));
      bus.dm_wdata = 16'($urandom);
    end
    if (g == 1)      begin m_addr = bus.if_addr; m_we = 1'b0;      m_wdata = 16'd0;        end
    else if (g == 2) begin m_addr = bus.dm_addr; m_we = bus.dm_we; m_wdata = bus.dm_wdata; end
    else             begin m_addr = 16'd0;       m_we = 1'b0;      m_wdata = 16'd0;        end
    #1;
    chk_eq("if_ack",    16'(bus.if_ack),    16'(g == 1));
    chk_eq("dm_ack",    16'(bus.dm_ack),    16'(g == 2));
    chk_eq("ram_we",    16'(bus.ram_we),    16'((g == 2) && m_we));
    chk_eq("ram_addr",  bus.ram_addr,       m_addr);
    if (g != 1) chk_eq("ram_wdata", bus.ram_wdata, m_wdata);
    chk_eq("if_stall",  16'(bus.if_stall),  16'(bus.if_req && (g != 1)));
    chk_eq("if_rvalid", 16'(bus.if_rvalid), 16'(exp_if_rv));
    chk_eq("dm_rvalid", 16'(bus.dm_rvalid), 16'(exp_dm_rv));
    chk_eq("if_rdata",  bus.if_rdata,       exp_if_rv ? exp_if_dat : 16'd0);
    chk_eq("dm_rdata",  bus.dm_rdata,       exp_dm_rv ? exp_dm_dat : 16'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_if_ack"},    16'(bus.if_ack),    16'd0);
    chk_eq({tag, "_dm_ack"},    16'(bus.dm_ack),    16'd0);
    chk_eq({tag, "_if_rvalid"}, 16'(bus.if_rvalid), 16'd0);
    chk_eq({tag, "_dm_rvalid"}, 16'(bus.dm_rvalid), 16'd0);
    chk_eq({tag, "_if_rdata"},  bus.if_rdata,       16'd0);
    chk_eq({tag, "_dm_rdata"},  bus.dm_rdata,       16'd0);
    chk_eq({tag, "_ram_we"},    16'(bus.ram_we),    16'd0);
    chk_eq({tag, "_ram_addr"},  bus.ram_addr,       16'd0);
  endtask

  task automatic quiet_requesters();
    p_if_new = 0; p_dm_new = 0; p_keep = 0; stream_mode = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_grant = 0; m_dm_run = 0; m_addr = 16'd0; m_wdata = 16'd0; m_we = 1'b0;
    exp_if_rv = 1'b0; exp_dm_rv = 1'b0; exp_if_dat = 16'd0; exp_dm_dat = 16'd0;
    if_adv = 1'b0; dm_adv = 1'b0;
    quiet_requesters();
    pre_we = 1'b0; pre_addr = 8'd0; pre_dat = 16'd0;
    bus.if_req = 1'b0; bus.if_addr = 16'd0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 16'd0; bus.dm_wdata = 16'd0;

    // reset, with RAM preload while it is held
    reset = 1'b1;
    #1;
    check_reset_outputs("reset");
    pre_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pre_addr  = 8'(i);
      pre_dat   = (i == 16) ? 16'hABCD : 16'($urandom);
      shadow[i] = pre_dat;
      @(posedge clk);
      #1;
    end
    pre_we = 1'b0;
    reset  = 1'b0;

    // idle: no requests, nothing happens
    repeat (3) step();
    chk_eq("idle_ram_we", 16'(bus.ram_we), 16'd0);

    // fetch only from 0x0010
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    step();
    chk_eq("fetch_ack", 16'(bus.if_ack), 16'd1);
    step();
    chk_eq("fetch_rvalid", 16'(bus.if_rvalid), 16'd1);
    chk_eq("fetch_rdata",  bus.if_rdata,       16'hABCD);
    step();

    // data write then fetch of the same address
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0020; bus.dm_wdata = 16'h1234;
    step();
    chk_eq("wr_ack", 16'(bus.dm_ack), 16'd1);
    bus.if_req = 1'b1; bus.if_addr = 16'h0020;
    step();
    chk_eq("rd_after_wr_ack", 16'(bus.if_ack), 16'd1);
    chk_eq("wr_no_dm_rvalid", 16'(bus.dm_rvalid), 16'd0);
    step();
    chk_eq("rd_after_wr_data", bus.if_rdata, 16'h1234);
    chk_eq("rd_after_wr_no_dm_rvalid", 16'(bus.dm_rvalid), 16'd0);
    step();

    // streaming fetch 0..3
    stream_mode = 1'b1; p_keep = 100;
    bus.if_req = 1'b1; bus.if_addr = 16'd0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) p_keep = 0;
      step();
      chk_eq("stream_ack",  16'(bus.if_ack), 16'd1);
      chk_eq("stream_addr", bus.ram_addr,    16'(k));
      if (k > 0) chk_eq("stream_rvalid", 16'(bus.if_rvalid), 16'd1);
    end
    step();
    chk_eq("stream_last_rvalid", 16'(bus.if_rvalid), 16'd1);
    chk_eq("stream_done_ack",    16'(bus.if_ack),    16'd0);
    step();
    chk_eq("stream_rvalid_off",  16'(bus.if_rvalid), 16'd0);
    quiet_requesters();

    // contention: both held continuously -> DM,DM,DM,IF repeating
    p_keep = 100;
    bus.if_req = 1'b1; bus.if_addr = rnd_addr();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = rnd_addr();
    for (int k = 0; k < 12; k++) begin
      step();
      chk_eq("contention_owner", {14'd0, bus.dm_ack, bus.if_ack},
             (k % 4 == 3) ? 16'd1 : 16'd2);
      if (k % 4 != 3) chk_eq("contention_stall", 16'(bus.if_stall), 16'd1);
    end
    p_keep = 0;
    repeat (8) step();

    // reset in the middle of a data access (write, then read)
    for (int w = 1; w >= 0; w--) begin
      quiet_requesters();
      bus.dm_req = 1'b1; bus.dm_we = 1'(w); bus.dm_addr = 16'h0030; bus.dm_wdata = 16'h5A5A;
      step();
      chk_eq("pre_rst_ram_we", 16'(bus.ram_we), 16'(w));
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_grant = 0; m_dm_run = 0; if_adv = 1'b0; dm_adv = 1'b0;
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      step();
      chk_eq("postrst_no_dm_rvalid", 16'(bus.dm_rvalid), 16'd0);
      step();
    end

    // randomized traffic against the model
    p_if_new = 40; p_dm_new = 40; p_keep = 50;
    repeat (3000) step();
    quiet_requesters();
    repeat (10) step();
    chk_eq("drain_if_req", 16'(bus.if_req), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
